cnn_result_streamer: RTL and testbench

- Output-side counterpart of image_streamer, placed after cnn_top.
- Captures the NUM_CLASSES signed class scores when cnn_top pulses its score-valid strobe, then computes the argmax sequentially.
- Transmits the scores, followed by the predicted class index, as a valid/ready word stream toward a host or UART bridge.
- Also presents a sticky pred_class/pred_valid pair for LEDs/debug.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/cnn_result_streamer.sv | 150 +++++++++++++++
 tb/tb_cnn_result_streamer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN result path.
// Score width, class count and the result streamer's FSM encoding.
package cnn_pkg;
    localparam int NUM_CLASSES = 10;
    localparam int ACC_W       = 32;
    localparam int IDX_W       = 4;
    localparam int WCNT_W      = $clog2(NUM_CLASSES + 1);

    typedef logic signed [ACC_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        ARGMAX,
        SEND
    } result_state_t;
endpackage

// File: rtl/cnn_result_streamer.sv
// Captures a score set, finds its argmax one compare per cycle, then streams scores + index.
// Latency: first word NUM_CLASSES cycles after capture; stalls on out_ready, flags overrun on busy in_valid.
module cnn_result_streamer
    import cnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ACC_W-1:0] in_scores [0:NUM_CLASSES-1],
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [IDX_W-1:0]        pred_class,
    output logic                    pred_valid,
    output logic                    overrun
);

    result_state_t           state_q, state_d;
    score_t                  score_q [0:NUM_CLASSES-1];
    score_t                  score_d [0:NUM_CLASSES-1];
    score_t                  best_q, best_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WCNT_W-1:0]       w_q, w_d;
    logic [ACC_W-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [IDX_W-1:0]        pred_class_q, pred_class_d;
    logic                    pred_valid_q, pred_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    in_ready_q, in_ready_d;

    logic                    take_new;
    logic [WCNT_W-1:0]       w_sel;
    logic                    w_sel_last;
    logic [ACC_W-1:0]        word_sel;

    // Strictly greater keeps the lowest index on ties.
    assign take_new = score_q[idx_q] > best_q;

    // While no word is presented, load word w; otherwise the handshake moves to w+1.
    assign w_sel      = out_valid_q ? w_q + 1'b1 : w_q;
    assign w_sel_last = (w_sel == WCNT_W'(NUM_CLASSES));
    assign word_sel   = w_sel_last ? ACC_W'(pred_class_q) : score_q[w_sel];

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        idx_d        = idx_q;
        w_d          = w_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        pred_class_d = pred_class_q;
        pred_valid_d = pred_valid_q;
        overrun_d    = overrun_q | (in_valid & ~in_ready_q);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    score_d      = in_scores;
                    best_d       = in_scores[0];
                    best_idx_d   = '0;
                    idx_d        = IDX_W'(1);
                    pred_valid_d = 1'b0;
                    state_d      = ARGMAX;
                end
            end
            ARGMAX: begin
                if (take_new) begin
                    best_d     = score_q[idx_q];
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
                    pred_class_d = take_new ? idx_q : best_idx_q;
                    pred_valid_d = 1'b1;
                    w_d          = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = word_sel;
                    out_last_d  = w_sel_last;
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        w_d        = w_sel;
                        out_data_d = word_sel;
                        out_last_d = w_sel_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            idx_q        <= '0;
            w_q          <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            pred_class_q <= '0;
            pred_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            idx_q        <= idx_d;
            w_q          <= w_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            pred_class_q <= pred_class_d;
            pred_valid_q <= pred_valid_d;
            overrun_q    <= overrun_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign pred_class = pred_class_q;
    assign pred_valid = pred_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_cnn_result_streamer.sv
// Directed bench for cnn_result_streamer: argmax, stream order, backpressure, overrun, reset.
module tb_cnn_result_streamer;
    import cnn_pkg::*;

    typedef logic signed [31:0] vec_t [10];

    logic         clk = 1'b0;
    logic         rst_n;
    vec_t         in_scores;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [3:0]   pred_class;
    logic         pred_valid;
    logic         overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cnn_result_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_scores  (in_scores),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .pred_class (pred_class),
        .pred_valid (pred_valid),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic capture(input vec_t v);
        @(negedge clk);
        in_scores = v;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: 3-cycle stall at word 4 then alternate 1/0.
    // ovr_at > 0 pulses in_valid with different scores at that cycle after capture.
    task automatic stream(input vec_t v, input int exp_pred, input int mode,
                          input int ovr_at, input string tag);
        int          n = 0;
        int          cyc = 0;
        int          k = 0;
        int          first = -1;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic [31:0] expw;
        while (n < 11 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == ovr_at) begin
                for (int i = 0; i < 10; i++) in_scores[i] = 77;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (prev_stall) begin
                chk($sformatf("%s_hold_d%0d", tag, n), out_data, prev_d);
                chk($sformatf("%s_hold_v%0d", tag, n), {31'd0, out_valid}, 32'd1);
            end
            if (mode == 1 && out_valid && n >= 4) begin
                out_ready = (k < 3) ? 1'b0 : (((k - 3) % 2) == 0);
                k++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && first < 0) first = cyc;
            if (out_valid && out_ready) begin
                expw = (n == 10) ? 32'(exp_pred) : 32'(v[n]);
                chk($sformatf("%s_w%0d", tag, n), out_data, expw);
                chk($sformatf("%s_last%0d", tag, n), {31'd0, out_last}, {31'd0, n == 10});
                if (n == 5) chk($sformatf("%s_busy_rdy", tag), {31'd0, in_ready}, 32'd0);
                n++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 32'(n), 32'd11);
        if (mode == 0) chk({tag, "_latency"}, 32'(first), 32'd10);
        @(negedge clk);
        chk({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_end_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_end_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_pred"}, {28'd0, pred_class}, 32'(exp_pred));
        chk({tag, "_pvalid"}, {31'd0, pred_valid}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   n;
        int   cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) in_scores[i] = 0;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd0);
        chk("rst_pvalid", {31'd0, pred_valid}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", {31'd0, in_ready}, 32'd1);

        v = '{5, -3, 12, 7, 0, -100, 12, 1, 2, 3};
        capture(v);
        stream(v, 2, 0, -1, "distinct");

        v = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1};
        capture(v);
        chk("pvalid_clr", {31'd0, pred_valid}, 32'd0);
        stream(v, 9, 0, -1, "neg");

        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -5};
        capture(v);
        stream(v, 8, 1, -1, "bp");

        v = '{42, 42, 42, 42, 42, 42, 42, 42, 42, 42};
        capture(v);
        stream(v, 0, 0, -1, "equal");
        chk("no_ovr", {31'd0, overrun}, 32'd0);

        v = '{3, 9, -2, 9, 4, 0, 1, 8, 7, 6};
        capture(v);
        stream(v, 1, 0, 3, "ovr");
        chk("ovr_flag", {31'd0, overrun}, 32'd1);

        v = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 8};
        capture(v);
        n   = 0;
        cyc = 0;
        while (n < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) n++;
        end
        chk("mid_words", 32'(n), 32'd6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_pvalid", {31'd0, pred_valid}, 32'd0);
        chk("arst_ovr", {31'd0, overrun}, 32'd0);
        chk("arst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerel_rdy", {31'd0, in_ready}, 32'd1);
        chk("rerel_valid", {31'd0, out_valid}, 32'd0);

        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
        capture(v);
        stream(v, 9, 0, -1, "fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
